// File: rtl/output_vote_classifier_if.sv
// Bundle between the network grid's output core and the vote classifier:
// the spike stream and frame marker go in, the classification result comes out.
interface output_vote_classifier_if #(
  parameter int NUM_CLASSES  = 9,
  parameter int PACKET_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
);
  localparam int CLS_W = $clog2(NUM_CLASSES);

  logic [PACKET_WIDTH-1:0] packet_out;
  logic                    packet_out_valid;
  logic                    frame_done;
  logic [CLS_W-1:0]        class_out;
  logic [COUNT_WIDTH-1:0]  max_votes;
  logic                    class_valid;
  logic                    busy;
  logic                    frame_overrun;

  modport master (
    output packet_out, packet_out_valid, frame_done,
    input  class_out, max_votes, class_valid, busy, frame_overrun
  );

  modport slave (
    input  packet_out, packet_out_valid, frame_done,
    output class_out, max_votes, class_valid, busy, frame_overrun
  );
endinterface

// File: rtl/output_vote_classifier.sv
// Per-class vote tally of the grid output stream; on frame_done the counts are
// snapshotted and scanned one class per cycle for the winner (ties -> lower index).
module output_vote_classifier #(
  parameter int NUM_CLASSES  = 9,
  parameter int PACKET_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  output_vote_classifier_if.slave   bus
);
  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [CLS_W-1:0]       LAST_IDX  = CLS_W'(NUM_CLASSES - 1);

  localparam logic [1:0] ST_COUNT = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]             state_reg;
  logic [CLS_W-1:0]       cls;
  logic [CLS_W-1:0]       scan_idx_reg;
  logic [CLS_W-1:0]       best_idx_reg;
  logic [CLS_W-1:0]       best_idx_next;
  logic [CLS_W-1:0]       class_out_reg;
  logic [COUNT_WIDTH-1:0] best_cnt_reg;
  logic [COUNT_WIDTH-1:0] best_cnt_next;
  logic [COUNT_WIDTH-1:0] scan_cnt;
  logic [COUNT_WIDTH-1:0] max_votes_reg;
  logic                   class_valid_reg;
  logic                   frame_overrun_reg;
  logic                   frame_accept;

  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0] snap_all;

  assign cls          = CLS_W'(32'(bus.packet_out) % 32'(NUM_CLASSES));
  assign frame_accept = bus.frame_done && (state_reg == ST_COUNT);

  // Live counters keep counting in every state; the snapshot takes the
  // same-cycle vote too, so nothing falls between two frames.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
      logic [COUNT_WIDTH-1:0] live_reg;
      logic [COUNT_WIDTH-1:0] live_next;
      logic [COUNT_WIDTH-1:0] snap_reg;

      always_comb begin
        live_next = live_reg;
        if (bus.packet_out_valid && (cls == CLS_W'(gi)) && (live_reg != COUNT_MAX))
          live_next = live_reg + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          live_reg <= '0;
          snap_reg <= '0;
        end else if (frame_accept) begin
          snap_reg <= live_next;
          live_reg <= '0;
        end else begin
          live_reg <= live_next;
        end
      end

      assign snap_all[gi] = snap_reg;
    end
  endgenerate

  assign scan_cnt = snap_all[scan_idx_reg];

  always_comb begin
    best_idx_next = best_idx_reg;
    best_cnt_next = best_cnt_reg;
    if (scan_cnt > best_cnt_reg) begin
      best_idx_next = scan_idx_reg;
      best_cnt_next = scan_cnt;
    end
  end

  // The result registers load on the last scan step, so they (and class_valid)
  // are visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_COUNT;
      scan_idx_reg      <= '0;
      best_idx_reg      <= '0;
      best_cnt_reg      <= '0;
      class_out_reg     <= '0;
      max_votes_reg     <= '0;
      class_valid_reg   <= 1'b0;
      frame_overrun_reg <= 1'b0;
    end else begin
      class_valid_reg   <= 1'b0;
      frame_overrun_reg <= bus.frame_done && (state_reg != ST_COUNT);
      case (state_reg)
        ST_COUNT: begin
          if (frame_accept) begin
            scan_idx_reg <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
            state_reg    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_idx_reg <= best_idx_next;
          best_cnt_reg <= best_cnt_next;
          if (scan_idx_reg == LAST_IDX) begin
            class_out_reg   <= best_idx_next;
            max_votes_reg   <= best_cnt_next;
            class_valid_reg <= 1'b1;
            state_reg       <= ST_DONE;
          end else begin
            scan_idx_reg <= scan_idx_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_COUNT;
        end
        default: begin
          state_reg <= ST_COUNT;
        end
      endcase
    end
  end

  assign bus.class_out     = class_out_reg;
  assign bus.max_votes     = max_votes_reg;
  assign bus.class_valid   = class_valid_reg;
  assign bus.busy          = (state_reg != ST_COUNT);
  assign bus.frame_overrun = frame_overrun_reg;
endmodule

// File: tb/tb_output_vote_classifier.sv
// Two classifiers (16-bit and 4-bit counters) share one stimulus stream; a
// frame-level model predicts results, busy windows and overrun pulses per cycle.
module tb_output_vote_classifier;
  localparam int N    = 9;
  localparam int PW   = 8;
  localparam int CW_A = 16;
  localparam int CW_B = 4;

  typedef struct {
    int cyc;
    int cls;
    int votes;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PW-1:0] packet = '0;
  logic valid = 1'b0;
  logic fd = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  res_t q[2][$];
  int held_cls[2];
  int held_votes[2];
  int live[N];
  bit exp_busy[int];
  bit exp_ovr[int];
  bit exp_rst[int];

  output_vote_classifier_if #(.NUM_CLASSES(N), .PACKET_WIDTH(PW), .COUNT_WIDTH(CW_A)) if_a ();
  output_vote_classifier_if #(.NUM_CLASSES(N), .PACKET_WIDTH(PW), .COUNT_WIDTH(CW_B)) if_b ();

  assign if_a.packet_out       = packet;
  assign if_a.packet_out_valid = valid;
  assign if_a.frame_done       = fd;
  assign if_b.packet_out       = packet;
  assign if_b.packet_out_valid = valid;
  assign if_b.frame_done       = fd;

  output_vote_classifier #(.NUM_CLASSES(N), .PACKET_WIDTH(PW), .COUNT_WIDTH(CW_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  output_vote_classifier #(.NUM_CLASSES(N), .PACKET_WIDTH(PW), .COUNT_WIDTH(CW_B)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Winner = first class whose saturated count equals the maximum saturated count.
  task automatic close_frame(input int c);
    for (int d = 0; d < 2; d++) begin
      int cap;
      int mx;
      int win;
      res_t r;
      cap = (d == 0) ? (1 << CW_A) - 1 : (1 << CW_B) - 1;
      mx = 0;
      for (int i = 0; i < N; i++) if ((live[i] > cap ? cap : live[i]) > mx) mx = (live[i] > cap ? cap : live[i]);
      win = 0;
      for (int i = N - 1; i >= 0; i--) if ((live[i] > cap ? cap : live[i]) == mx) win = i;
      r.cyc = c + N + 1;
      r.cls = win;
      r.votes = mx;
      q[d].push_back(r);
    end
    for (int k = c + 1; k <= c + N + 1; k++) exp_busy[k] = 1'b1;
    for (int i = 0; i < N; i++) live[i] = 0;
  endtask

  task automatic step(input bit r, input bit v, input int p, input bit f);
    int c;
    rst = r;
    valid = v;
    packet = PW'(p);
    fd = f;
    c = cyc;
    if (r) begin
      for (int i = 0; i < N; i++) live[i] = 0;
      for (int k = c + 1; k <= c + N + 2; k++) exp_busy.delete(k);
      for (int d = 0; d < 2; d++)
        while (q[d].size() > 0 && q[d][$].cyc > c) void'(q[d].pop_back());
      exp_rst[c + 1] = 1'b1;
    end else begin
      if (v) live[p % N]++;
      if (f) begin
        if (exp_busy.exists(c)) exp_ovr[c + 1] = 1'b1;
        else close_frame(c);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * N && exp_busy.exists(cyc); i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic mon_one(input int d, input int cv, input int co, input int mv, input int bz, input int ov);
    bit due;
    if (exp_rst.exists(cyc)) begin
      held_cls[d] = 0;
      held_votes[d] = 0;
    end
    if (q[d].size() > 0 && q[d][0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_result dut%0d cyc %0d: got no class_valid expected one at cyc %0d",
               d, cyc, q[d][0].cyc);
      void'(q[d].pop_front());
    end
    due = (q[d].size() > 0) && (q[d][0].cyc == cyc);
    chk("class_valid", d, cv, int'(due));
    if (due) begin
      held_cls[d] = q[d][0].cls;
      held_votes[d] = q[d][0].votes;
      void'(q[d].pop_front());
      $display("result dut%0d cyc %0d: class %0d votes %0d (expected %0d/%0d)",
               d, cyc, co, mv, held_cls[d], held_votes[d]);
    end
    chk("class_out", d, co, held_cls[d]);
    chk("max_votes", d, mv, held_votes[d]);
    chk("busy", d, bz, int'(exp_busy.exists(cyc)));
    chk("frame_overrun", d, ov, int'(exp_ovr.exists(cyc)));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, int'(if_a.class_valid), int'(if_a.class_out), int'(if_a.max_votes),
              int'(if_a.busy), int'(if_a.frame_overrun));
      mon_one(1, int'(if_b.class_valid), int'(if_b.class_out), int'(if_b.max_votes),
              int'(if_b.busy), int'(if_b.frame_overrun));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) live[i] = 0;
    for (int d = 0; d < 2; d++) begin
      held_cls[d] = 0;
      held_votes[d] = 0;
    end

    // Reset held with votes toggling, then an empty frame.
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 3, 1'b0);
    mon_en = 1'b1;
    idle(2);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Basic vote: class 4 wins with 3.
    step(1'b0, 1'b1, 4, 1'b0);
    step(1'b0, 1'b1, 13, 1'b0);
    step(1'b0, 1'b1, 22, 1'b0);
    step(1'b0, 1'b1, 7, 1'b0);
    step(1'b0, 1'b1, 16, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Tie between classes 2 and 5, deciding vote arrives with frame_done.
    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b1, 14, 1'b0);
    step(1'b0, 1'b1, 11, 1'b0);
    step(1'b0, 1'b1, 2, 1'b1);
    wait_idle();

    // Overlap: votes and a second frame_done during the scan.
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 8, 1'b0);
    step(1'b0, 1'b1, 8, 1'b0);
    step(1'b0, 1'b1, 8, 1'b1);
    step(1'b0, 1'b1, 8, 1'b0);
    step(1'b0, 1'b1, 8, 1'b0);
    wait_idle();
    step(1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Saturation of the narrow counter.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1 + 9 * (i % 3), 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Reset in the middle of a scan, then an empty frame.
    step(1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(3);
    step(1'b1, 1'b1, 6, 1'b0);
    step(1'b0, 1'b1, 6, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Random traffic with occasional frame ends and resets.
    for (int i = 0; i < 900; i++) begin
      bit r;
      bit v;
      bit f;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 11) == 0);
      step(r, v, int'($urandom_range(0, 255)), f);
    end
    wait_idle();
    idle(3);

    checks++;
    if (q[0].size() + q[1].size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", q[0].size() + q[1].size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
